noc_pkt_injector: RTL and testbench
===================================

NOC_PKT_INJECTOR -- requirements
Module: noc_pkt_injector

Interface
REQ-001 Parameter FLIT_WIDTH, default 32: payload bits per flit, excluding the last marker.
REQ-002 Parameter MAX_LEN, default 8: maximum packet length in flits, header included; legal range 2..16.
REQ-003 Parameter SRC_ID, default 0: 5-bit source tile ID placed in every header.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 cmd_valid  in  1  packet command offered.
REQ-007 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-008 cmd_dest  in  5  destination tile ID.
REQ-009 cmd_class  in  3  message class.
REQ-010 cmd_len  in  4  total flits, header included.
REQ-011 cmd_seed  in  16  payload seed.
REQ-012 out_flit  out  FLIT_WIDTH  flit data toward the NoC link.
REQ-013 out_last  out  1  marks the final flit of a packet.
REQ-014 out_valid  out  1  flit offered.
REQ-015 out_ready  in  1  link accepts the flit.
REQ-016 busy  out  1  high while a packet is in progress.
REQ-017 pkt_count  out  32  number of completed packets.

Function
REQ-018 The FSM SHALL have three states: IDLE, HEADER and PAYLOAD.
REQ-019 In IDLE, cmd_ready SHALL be 1. In HEADER and PAYLOAD, cmd_ready SHALL be 0.
REQ-020 When cmd_valid and cmd_ready are both high, the block SHALL latch dest, class, seed and the effective length, then move to HEADER on the next edge.
REQ-021 Effective length SHALL be computed as follows:
- cmd_len 0 is treated as 1.
- cmd_len greater than MAX_LEN is clamped to MAX_LEN.
REQ-022 The header flit SHALL be laid out as follows:
- bits [31:27] = dest
- bits [26:24] = class
- bits [23:19] = SRC_ID
- bits [18:16] = 0
- bits [15:0] = pkt_seq
REQ-023 Payload flit k (k = 1..len-1) SHALL be {pkt_seq[15:0], (seed + k) mod 2^16}.
REQ-024 out_valid SHALL be 1 in HEADER and PAYLOAD, and 0 in IDLE.
REQ-025 A flit SHALL transfer on any edge where out_valid and out_ready are both high.
REQ-026 While out_valid=1 and out_ready=0, out_flit and out_last SHALL hold stable.
REQ-027 out_valid SHALL never deassert before its flit transfers.
REQ-028 State transitions after a header transfer:
- If effective length is 1, the header carries out_last=1 and the FSM returns to IDLE.
- Otherwise the FSM moves to PAYLOAD.
REQ-029 A 4-bit flit index SHALL advance on each payload transfer. out_last SHALL be 1 exactly when index = len-1.
REQ-030 On transfer of a last flit, the FSM SHALL return to IDLE. pkt_seq (16-bit) and pkt_count (32-bit) SHALL each increment by 1, wrapping modulo 2^width.
REQ-031 Throughput SHALL be one flit per cycle while out_ready=1. There SHALL be exactly one idle cycle between the last flit of a packet and the next header.
REQ-032 busy SHALL equal (state != IDLE).
REQ-033 When out_valid=0, out_flit and out_last SHALL be 0.

Reset
REQ-034 Asserting rst SHALL immediately force:
- state = IDLE
- out_valid = 0, out_last = 0, out_flit = 0
- busy = 0
- pkt_count = 0, pkt_seq = 0, index = 0
REQ-035 Reset asserted mid-packet SHALL abort the packet without completing it. pkt_count SHALL NOT increment. cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-036 Basic packet. Stimulus: rst released; command dest=3, class=0, len=3, seed=0x0010; out_ready=1 throughout. Response:
- header 0x18000000
- payload 0x00000011, then 0x00000012 with out_last=1
- pkt_count=1 afterwards.
REQ-037 Backpressure. Stimulus: same command with out_ready toggling 0,0,1 per flit. Response: each flit holds stable for 3 cycles; the flit sequence is unchanged; pkt_seq field = 0x0001.
REQ-038 Length boundaries. Stimulus: cmd_len=0, then cmd_len=15 with MAX_LEN=8. Response:
- a single header flit with out_last=1
- an 8-flit packet with last on flit 8.
REQ-039 Seed wrap. Stimulus: seed=0xFFFE, len=4. Response: payload low halves 0xFFFF, 0x0000, 0x0001.
REQ-040 Reset mid-packet. Stimulus: rst asserted after the second of 5 flits. Response:
- out_valid=0 asynchronously
- pkt_count=0
- the next command produces a header with pkt_seq=0.
REQ-041 Back-to-back commands. Stimulus: cmd_valid held high for 3 commands of len=2, out_ready=1. Response:
- cmd_ready is high only in IDLE cycles
- 6 flits delivered with one bubble between packets
- pkt_count=3.

Source files
------------

// File: rtl/noc_pkt_injector_if.sv
// noc_pkt_injector_if
// Bundles the command handshake and the outgoing flit link of the packet
// injector.
//   cmd_valid/cmd_ready          command handshake
//   cmd_dest/class/len/seed      command fields (dest 5b, class 3b, len 4b, seed 16b)
//   out_flit/out_last            flit data and end-of-packet marker
//   out_valid/out_ready          flit handshake toward the NoC link
// Modport 'master' is the injector's own view: it accepts commands and
// masters the flit link. Modport 'slave' is the environment's view:
// it issues commands and sinks flits.

interface noc_pkt_injector_if #(
    parameter int FLIT_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [4:0]            cmd_dest;
    logic [2:0]            cmd_class;
    logic [3:0]            cmd_len;
    logic [15:0]           cmd_seed;

    logic [FLIT_WIDTH-1:0] out_flit;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_dest,
        input  cmd_class,
        input  cmd_len,
        input  cmd_seed,
        output out_flit,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output cmd_valid,
        input  cmd_ready,
        output cmd_dest,
        output cmd_class,
        output cmd_len,
        output cmd_seed,
        input  out_flit,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/noc_pkt_injector.sv
// noc_pkt_injector
// Turns a packet command into a header flit followed by len-1 payload
// flits on a valid/ready link. Every flit is computed one transfer ahead
// and held in registers, so out_flit/out_last never change while a flit
// waits for out_ready.
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   bus        command handshake + flit link (noc_pkt_injector_if.master)
//   busy       high while a packet is in progress
//   pkt_count  completed packets, wraps at 2^32
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no packet; cmd_ready=1, out_valid=0
// HEADER  | header flit offered on the link
// PAYLOAD | payload flit 'index' offered on the link

module noc_pkt_injector #(
    parameter int FLIT_WIDTH = 32,
    parameter int MAX_LEN    = 8,
    parameter int SRC_ID     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_pkt_injector_if.master   bus,
    output logic                 busy,
    output logic [31:0]          pkt_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    localparam logic [4:0] SRC       = 5'(SRC_ID);
    localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);
    localparam logic [3:0] MAX_LEN_M1 = 4'(MAX_LEN - 1);

    state_t      state;
    logic [15:0] seed_q;
    logic [15:0] pkt_seq;
    logic [3:0]  len_m1;      // effective length minus one
    logic [3:0]  index;
    logic [3:0]  next_index;
    logic [3:0]  eff_len_m1;
    logic        xfer;

    // Zero-extends a 32-bit flit image to the link width.
    function automatic logic [FLIT_WIDTH-1:0] widen(input logic [31:0] v);
        logic [FLIT_WIDTH-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    assign xfer       = bus.out_valid && bus.out_ready;
    assign next_index = index + 4'd1;

    // Length 0 behaves as a header-only packet; oversize requests clamp.
    always_comb begin
        eff_len_m1 = bus.cmd_len - 4'd1;
        if (bus.cmd_len == 4'd0) begin
            eff_len_m1 = 4'd0;
        end else if ({1'b0, bus.cmd_len} > MAX_LEN_W) begin
            eff_len_m1 = MAX_LEN_M1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            seed_q        <= '0;
            pkt_seq       <= '0;
            len_m1        <= '0;
            index         <= '0;
            pkt_count     <= '0;
            busy          <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_flit  <= '0;
        end else if (xfer && bus.out_last) begin
            // Final flit of the packet leaves; out_last is only ever set
            // on the flit whose index equals len-1.
            state         <= IDLE;
            index         <= '0;
            pkt_seq       <= pkt_seq + 16'd1;
            pkt_count     <= pkt_count + 32'd1;
            busy          <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_flit  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        // dest/class live on only inside the registered
                        // header, so they are not kept separately.
                        seed_q        <= bus.cmd_seed;
                        len_m1        <= eff_len_m1;
                        index         <= '0;
                        state         <= HEADER;
                        busy          <= 1'b1;
                        bus.cmd_ready <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= (eff_len_m1 == 4'd0);
                        bus.out_flit  <= widen({bus.cmd_dest, bus.cmd_class,
                                                SRC, 3'b000, pkt_seq});
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        state        <= PAYLOAD;
                        index        <= 4'd1;
                        bus.out_last <= (len_m1 == 4'd1);
                        bus.out_flit <= widen({pkt_seq, seed_q + 16'd1});
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        index        <= next_index;
                        bus.out_last <= (next_index == len_m1);
                        bus.out_flit <= widen({pkt_seq,
                                               seed_q + {12'b0, next_index}});
                    end
                end
                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                    bus.out_flit  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_pkt_injector.sv
// tb_noc_pkt_injector
// Self-checking bench for noc_pkt_injector: expected flits are pushed to a
// scoreboard queue when a command is issued and compared as the DUT
// transfers them. Per-cycle protocol checks run alongside.

module tb_noc_pkt_injector;
    localparam int FW = 32;
    localparam logic [4:0] SRC = 5'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [31:0] pkt_count;

    always #5 clk = ~clk;

    noc_pkt_injector_if #(.FLIT_WIDTH(FW)) bus ();

    noc_pkt_injector #(
        .FLIT_WIDTH(FW),
        .MAX_LEN   (8),
        .SRC_ID    (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .pkt_count(pkt_count)
    );

    typedef struct {
        logic [31:0] flit;
        logic        last;
    } exp_t;

    typedef struct {
        logic [4:0]  dest;
        logic [2:0]  cls;
        logic [3:0]  len;
        logic [15:0] seed;
        int          exp_len;
    } vec_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_seq = '0;
    logic [31:0] exp_count = '0;
    bit          rand_mode = 1'b0;
    bit          bp_mode   = 1'b0;
    bit          b2b_mode  = 1'b0;
    logic        ready_force = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // out_ready driver: random in rand_mode, otherwise follows ready_force.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Monitor / scoreboard, sampling on the falling edge.
    int          cyc = 0;
    int          hold_cnt = 0;
    int          prev_cyc = 0;
    bit          have_prev = 1'b0;
    bit          prev_last = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [32:0] prev_img = '0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            hold_cnt   = 0;
            prev_valid = 1'b0;
            have_prev  = 1'b0;
        end else begin
            chk("busy_vs_valid", 64'(busy), 64'(bus.out_valid));
            chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'(!busy));
            if (!bus.out_valid)
                chk("idle_flit_zero", 64'({bus.out_last, bus.out_flit}), 64'd0);
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_flit", 64'({bus.out_last, bus.out_flit}), 64'(prev_img));
            end
            if (bus.out_valid) hold_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flit actual=%0h required=none", bus.out_flit);
                end else begin
                    e = sbq.pop_front();
                    chk("flit", 64'(bus.out_flit), 64'(e.flit));
                    chk("last", 64'(bus.out_last), 64'(e.last));
                end
                if (bp_mode) chk("bp_hold_cycles", 64'(hold_cnt), 64'd3);
                if (b2b_mode && have_prev)
                    chk("b2b_gap", 64'(cyc - prev_cyc), prev_last ? 64'd2 : 64'd1);
                have_prev = b2b_mode;
                prev_cyc  = cyc;
                prev_last = bus.out_last;
                hold_cnt  = 0;
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_img   = {bus.out_last, bus.out_flit};
        end
    end

    task automatic push_flit(input logic [31:0] f, input logic l);
        exp_t e;
        e.flit = f;
        e.last = l;
        sbq.push_back(e);
    endtask

    task automatic push_model(input logic [4:0] d, input logic [2:0] c,
                              input logic [15:0] s, input int exp_len);
        push_flit({d, c, SRC, 3'b000, model_seq}, exp_len == 1);
        for (int k = 1; k < exp_len; k++)
            push_flit({model_seq, s + 16'(k)}, k == exp_len - 1);
        model_seq++;
        exp_count++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_cmd(input logic [4:0] d, input logic [2:0] c,
                            input logic [3:0] l, input logic [15:0] s, input bit hold);
        bit ok;
        bus.cmd_dest  = d;
        bus.cmd_class = c;
        bus.cmd_len   = l;
        bus.cmd_seed  = s;
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("cmd_accept", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 64'(done), 64'd1);
        chk("pkt_count", 64'(pkt_count), 64'(exp_count));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[7];

    initial begin
        vecs[0] = '{5'd1,  3'd2, 4'd0,  16'h1234, 1};
        vecs[1] = '{5'd7,  3'd5, 4'd15, 16'h0100, 8};
        vecs[2] = '{5'd9,  3'd1, 4'd4,  16'hFFFE, 4};
        vecs[3] = '{5'd31, 3'd7, 4'd1,  16'hABCD, 1};
        vecs[4] = '{5'd0,  3'd3, 4'd8,  16'h7FFF, 8};
        vecs[5] = '{5'd16, 3'd4, 4'd9,  16'h0000, 8};
        vecs[6] = '{5'd2,  3'd6, 4'd2,  16'h5555, 2};

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_dest  = '0;
        bus.cmd_class = '0;
        bus.cmd_len   = '0;
        bus.cmd_seed  = '0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_flit", 64'({bus.out_last, bus.out_flit}), 64'd0);
        #21;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        @(posedge clk);
        #1;

        // Basic packet.
        ready_force = 1'b1;
        push_flit(32'h18000000, 1'b0);
        push_flit(32'h00000011, 1'b0);
        push_flit(32'h00000012, 1'b1);
        model_seq = 16'd1;
        exp_count = 32'd1;
        send_cmd(5'd3, 3'd0, 4'd3, 16'h0010, 1'b0);
        wait_done("basic_done");

        // Backpressure: each flit waits two cycles, then transfers.
        ready_force = 1'b0;
        bp_mode     = 1'b1;
        push_flit(32'h18000001, 1'b0);
        push_flit(32'h00010011, 1'b0);
        push_flit(32'h00010012, 1'b1);
        model_seq = 16'd2;
        exp_count = 32'd2;
        send_cmd(5'd3, 3'd0, 4'd3, 16'h0010, 1'b0);
        for (int f = 0; f < 3; f++) begin
            ready_force = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            ready_force = 1'b1;
            @(posedge clk); #1;
        end
        wait_done("bp_done");
        bp_mode = 1'b0;

        // Table vectors under random backpressure.
        rand_mode = 1'b1;
        for (int v = 0; v < 7; v++) begin
            push_model(vecs[v].dest, vecs[v].cls, vecs[v].seed, vecs[v].exp_len);
            send_cmd(vecs[v].dest, vecs[v].cls, vecs[v].len, vecs[v].seed, 1'b0);
            wait_done("vec_done");
        end
        rand_mode   = 1'b0;
        ready_force = 1'b1;
        @(posedge clk); #1;

        // Reset after the second of five flits.
        push_model(5'd4, 3'd1, 16'h0200, 5);
        send_cmd(5'd4, 3'd1, 4'd5, 16'h0200, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_flit", 64'({bus.out_last, bus.out_flit}), 64'd0);
        chk("mid_rst_count", 64'(pkt_count), 64'd0);
        sbq.delete();
        model_seq = '0;
        exp_count = '0;
        @(posedge clk);
        #4;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk); #1;
        push_flit(32'h18000000, 1'b0);
        push_flit(32'h00000001, 1'b1);
        model_seq = 16'd1;
        exp_count = 32'd1;
        send_cmd(5'd3, 3'd0, 4'd2, 16'h0000, 1'b0);
        wait_done("post_rst_done");

        // Back-to-back commands with cmd_valid held high.
        b2b_mode = 1'b1;
        for (int n = 0; n < 3; n++) begin
            push_model(5'd5, 3'd2, 16'(16'h0100 * n), 2);
            send_cmd(5'd5, 3'd2, 4'd2, 16'(16'h0100 * n), n != 2);
        end
        wait_done("b2b_done");
        b2b_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
